// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from hsync/vsync
// samples taken on p_tick and checks line/frame timing to establish lock.
module vga_sync_monitor #(
  parameter int H_DISP       = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC       = 96,
  parameter int V_DISP       = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC       = 2,
  parameter bit SYNC_POL     = 1'b1,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       locked,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int GF_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0]      X_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      Y_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      X_SYNC  = 10'(H_SYNC_START);
  localparam logic [9:0]      Y_SYNC  = 10'(V_SYNC_START);
  localparam logic [9:0]      X_DISP  = 10'(H_DISP);
  localparam logic [9:0]      Y_DISP  = 10'(V_DISP);
  localparam logic [10:0]     HP_NOM  = 11'(H_TOTAL);
  localparam logic [10:0]     HP_TMO  = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0]     HW_NOM  = 11'(H_SYNC);
  localparam logic [19:0]     VP_NOM  = 20'(H_TOTAL * V_TOTAL);
  localparam logic [11:0]     VW_NOM  = 12'(V_SYNC * H_TOTAL);
  localparam logic [GF_W-1:0] GF_LOCK = GF_W'(LOCK_FRAMES);

  logic            hs, vs, hs_prev, vs_prev;
  logic            hs_rise, hs_fall, vs_rise, vs_fall;
  logic [9:0]      x_d, y_d;
  logic [10:0]     hp, hw;
  logic [19:0]     vp;
  logic [11:0]     vw;
  logic            h_seen, h_armed, v_seen, v_armed, err_seen;
  logic [GF_W-1:0] good_frames, gf_d;
  logic            line_e, frame_e, err_any;

  // Normalised syncs: 1 always means asserted regardless of polarity.
  assign hs = hsync_in ~^ SYNC_POL;
  assign vs = vsync_in ~^ SYNC_POL;

  assign hs_rise = p_tick & hs & ~hs_prev;
  assign hs_fall = p_tick & ~hs & hs_prev;
  assign vs_rise = p_tick & vs & ~vs_prev;
  assign vs_fall = p_tick & ~vs & vs_prev;

  // Timeout fires only on the tick hp steps onto 2*H_TOTAL, so it cannot repeat.
  assign line_e  = (hs_rise & h_seen & (hp != HP_NOM))
                 | (hs_fall & h_armed & (hw != HW_NOM))
                 | (p_tick & ~hs_rise & (hp == HP_TMO));
  assign frame_e = (vs_rise & v_seen & (vp != VP_NOM))
                 | (vs_fall & v_armed & (vw != VW_NOM));
  assign err_any = line_e | frame_e;

  assign video_on = locked && (pixel_x < X_DISP) && (pixel_y < Y_DISP);

  always_comb begin
    x_d = pixel_x;
    y_d = pixel_y;
    if (hs_rise) begin
      x_d = X_SYNC;
    end else if (pixel_x == X_MAX) begin
      x_d = '0;
      y_d = (pixel_y == Y_MAX) ? '0 : pixel_y + 10'd1;
    end else begin
      x_d = pixel_x + 10'd1;
    end
    if (vs_rise) y_d = Y_SYNC;
  end

  // A frame counts as good only if no error occurred since the previous vs edge.
  always_comb begin
    gf_d = good_frames;
    if (err_any) begin
      gf_d = '0;
    end else if (vs_rise && v_seen && !err_seen && good_frames != GF_LOCK) begin
      gf_d = good_frames + GF_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hp          <= '0;
      hw          <= '0;
      vp          <= '0;
      vw          <= '0;
      h_seen      <= 1'b0;
      h_armed     <= 1'b0;
      v_seen      <= 1'b0;
      v_armed     <= 1'b0;
      err_seen    <= 1'b0;
      good_frames <= '0;
      locked      <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      line_err    <= line_e;
      frame_err   <= frame_e;
      good_frames <= gf_d;
      locked      <= (gf_d == GF_LOCK);
      if (err_any && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (p_tick) begin
        hs_prev <= hs;
        vs_prev <= vs;
        pixel_x <= x_d;
        pixel_y <= y_d;
        if (hs_rise) begin
          hp      <= 11'd1;
          h_seen  <= 1'b1;
          hw      <= 11'd1;
          h_armed <= 1'b1;
        end else begin
          if (hp != '1) hp <= hp + 11'd1;
          if (hs && hw != '1) hw <= hw + 11'd1;
        end
        if (vs_rise) begin
          vp      <= 20'd1;
          v_seen  <= 1'b1;
          vw      <= 12'd1;
          v_armed <= 1'b1;
        end else begin
          if (vp != '1) vp <= vp + 20'd1;
          if (vs && vw != '1) vw <= vw + 12'd1;
        end
        if (vs_rise) err_seen <= 1'b0;
        else if (err_any) err_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down mode; one instance per sync
// polarity, both fed the same timing and held to the same expectations.
module tb_vga_sync_monitor;

  localparam int H_DISP = 16, H_TOTAL = 24, HSS = 18, HSW = 3;
  localparam int V_DISP = 10, V_TOTAL = 14, VSS = 11, VSW = 2;
  localparam int FRAME  = H_TOTAL * V_TOTAL;

  logic       Clk = 1'b0;
  logic       reset, p_tick;
  logic       hsync_a, vsync_a, hsync_b, vsync_b;
  logic       locked_a, locked_b, video_on_a, video_on_b;
  logic       line_err_a, line_err_b, frame_err_a, frame_err_b;
  logic [9:0] pixel_x_a, pixel_x_b, pixel_y_a, pixel_y_b;
  logic [7:0] err_count_a, err_count_b;

  always #5 Clk = ~Clk;

  vga_sync_monitor #(
    .H_DISP(H_DISP), .H_TOTAL(H_TOTAL), .H_SYNC_START(HSS), .H_SYNC(HSW),
    .V_DISP(V_DISP), .V_TOTAL(V_TOTAL), .V_SYNC_START(VSS), .V_SYNC(VSW),
    .SYNC_POL(1'b1), .LOCK_FRAMES(2)
  ) u_dut_a (
    .Clk(Clk), .reset(reset), .p_tick(p_tick), .hsync_in(hsync_a), .vsync_in(vsync_a),
    .locked(locked_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .video_on(video_on_a),
    .line_err(line_err_a), .frame_err(frame_err_a), .err_count(err_count_a)
  );

  vga_sync_monitor #(
    .H_DISP(H_DISP), .H_TOTAL(H_TOTAL), .H_SYNC_START(HSS), .H_SYNC(HSW),
    .V_DISP(V_DISP), .V_TOTAL(V_TOTAL), .V_SYNC_START(VSS), .V_SYNC(VSW),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) u_dut_b (
    .Clk(Clk), .reset(reset), .p_tick(p_tick), .hsync_in(hsync_b), .vsync_in(vsync_b),
    .locked(locked_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .video_on(video_on_b),
    .line_err(line_err_b), .frame_err(frame_err_b), .err_count(err_count_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int lc_a = 0, lc_b = 0, fc_a = 0, fc_b = 0;

  // Pulse counters: a pulse held longer than one Clk is counted twice.
  always @(negedge Clk) begin
    if (line_err_a)  lc_a <= lc_a + 1;
    if (line_err_b)  lc_b <= lc_b + 1;
    if (frame_err_a) fc_a <= fc_a + 1;
    if (frame_err_b) fc_b <= fc_b + 1;
  end

  typedef struct {
    int sx;
    int sy;
    int ex;
    int ey;
    bit ev;
  } coord_vec_t;

  coord_vec_t vecs[10];

  int gx, gy, line_len, line_hsw;
  bit hs_en;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_ab(input string name, input int act_a, input int act_b, input int exp);
    check({name, "_pol1"}, act_a, exp);
    check({name, "_pol0"}, act_b, exp);
  endtask

  task automatic step();
    logic hs, vs;
    hs = hs_en && (gx >= HSS) && (gx < HSS + line_hsw);
    vs = (gy >= VSS) && (gy < VSS + VSW);
    hsync_a = hs;
    vsync_a = vs;
    hsync_b = ~hs;
    vsync_b = ~vs;
    p_tick  = 1'b1;
    @(posedge Clk); #1;
    p_tick  = 1'b0;
    @(posedge Clk); #1;
    if (gx >= line_len - 1) begin
      gx = 0;
      gy = (gy == V_TOTAL - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(gx == x && gy == y) && n < 2 * FRAME) begin
      step();
      n++;
    end
    if (!(gx == x && gy == y)) begin
      n_checks++;
      $display("FAIL run_to: stopped at (%0d,%0d) required (%0d,%0d)", gx, gy, x, y);
    end
  endtask

  task automatic run_vs_edge();
    run_to(0, VSS);
    step();
  endtask

  int lc0, fc0;

  initial begin
    vecs[0] = '{0,  0,  0,  0,  1'b1};
    vecs[1] = '{5,  3,  5,  3,  1'b1};
    vecs[2] = '{15, 9,  15, 9,  1'b1};
    vecs[3] = '{16, 9,  16, 9,  1'b0};
    vecs[4] = '{18, 9,  18, 9,  1'b0};
    vecs[5] = '{23, 9,  23, 9,  1'b0};
    vecs[6] = '{0,  10, 0,  10, 1'b0};
    vecs[7] = '{0,  11, 0,  11, 1'b0};
    vecs[8] = '{23, 13, 23, 13, 1'b0};
    vecs[9] = '{0,  0,  0,  0,  1'b1};

    reset = 1'b1; p_tick = 1'b0;
    hsync_a = 1'b0; vsync_a = 1'b0; hsync_b = 1'b1; vsync_b = 1'b1;
    gx = 0; gy = 0; line_len = H_TOTAL; line_hsw = HSW; hs_en = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_ab("rst_locked", locked_a, locked_b, 0);
    check_ab("rst_pixel_x", pixel_x_a, pixel_x_b, 0);
    check_ab("rst_pixel_y", pixel_y_a, pixel_y_b, 0);
    check_ab("rst_video_on", video_on_a, video_on_b, 0);
    check_ab("rst_err_count", err_count_a, err_count_b, 0);
    @(negedge Clk);
    reset = 1'b0;

    // Nominal timing: lock lands on the third vs assertion edge.
    for (int e = 0; e < 3; e++) begin
      run_vs_edge();
      check_ab($sformatf("lock_edge%0d", e), locked_a, locked_b, (e == 2) ? 1 : 0);
    end
    check_ab("nom_err_count", err_count_a, err_count_b, 0);
    check_ab("nom_line_pulses", lc_a, lc_b, 0);
    check_ab("nom_frame_pulses", fc_a, fc_b, 0);

    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].sx, vecs[i].sy);
      step();
      check_ab($sformatf("v%0d_pixel_x", i), pixel_x_a, pixel_x_b, vecs[i].ex);
      check_ab($sformatf("v%0d_pixel_y", i), pixel_y_a, pixel_y_b, vecs[i].ey);
      check_ab($sformatf("v%0d_video_on", i), video_on_a, video_on_b, int'(vecs[i].ev));
    end

    // One line stretched by a tick: hsync period error, then frame period error.
    run_to(0, 2);
    line_len = H_TOTAL + 1;
    run_to(0, 3);
    line_len = H_TOTAL;
    run_to(HSS, 3);
    check_ab("str_pre_line_pulses", lc_a, lc_b, 0);
    step();
    check_ab("str_line_pulses", lc_a, lc_b, 1);
    check_ab("str_locked", locked_a, locked_b, 0);
    check_ab("str_err_count1", err_count_a, err_count_b, 1);
    run_vs_edge();
    check_ab("str_frame_pulses", fc_a, fc_b, 1);
    check_ab("str_err_count2", err_count_a, err_count_b, 2);
    check_ab("str_locked_edge0", locked_a, locked_b, 0);
    run_vs_edge();
    check_ab("str_locked_edge1", locked_a, locked_b, 0);
    run_vs_edge();
    check_ab("str_locked_edge2", locked_a, locked_b, 1);
    check_ab("str_line_pulses_end", lc_a, lc_b, 1);
    check_ab("str_frame_pulses_end", fc_a, fc_b, 1);

    // hsync one tick short: flagged at its deassertion edge only.
    run_to(0, 3);
    line_hsw = HSW - 1;
    run_to(HSS + HSW - 1, 3);
    check_ab("wid_pre_line_pulses", lc_a, lc_b, 1);
    step();
    check_ab("wid_line_pulses", lc_a, lc_b, 2);
    check_ab("wid_err_count", err_count_a, err_count_b, 3);
    check_ab("wid_locked", locked_a, locked_b, 0);
    run_to(0, 4);
    line_hsw = HSW;
    for (int e = 0; e < 3; e++) begin
      run_vs_edge();
      check_ab($sformatf("wid_relock_edge%0d", e), locked_a, locked_b, (e == 2) ? 1 : 0);
    end
    check_ab("wid_line_pulses_end", lc_a, lc_b, 2);
    check_ab("wid_frame_pulses_end", fc_a, fc_b, 1);

    // Asynchronous reset while locked, released in the middle of an hsync pulse.
    run_to(HSS + 2, 5);
    #2;
    reset = 1'b1;
    #1;
    check_ab("mid_rst_locked", locked_a, locked_b, 0);
    check_ab("mid_rst_pixel_x", pixel_x_a, pixel_x_b, 0);
    check_ab("mid_rst_pixel_y", pixel_y_a, pixel_y_b, 0);
    check_ab("mid_rst_video_on", video_on_a, video_on_b, 0);
    check_ab("mid_rst_err_count", err_count_a, err_count_b, 0);
    check_ab("mid_rst_line_err", line_err_a, line_err_b, 0);
    check_ab("mid_rst_frame_err", frame_err_a, frame_err_b, 0);
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    @(posedge Clk); #1;
    lc0 = lc_a;
    fc0 = fc_a;
    for (int e = 0; e < 3; e++) begin
      run_vs_edge();
      check_ab($sformatf("rel_lock_edge%0d", e), locked_a, locked_b, (e == 2) ? 1 : 0);
    end
    check_ab("rel_line_pulses", lc_a, lc_b, lc0);
    check_ab("rel_frame_pulses", fc_a, fc_b, fc0);
    check_ab("rel_err_count", err_count_a, err_count_b, 0);

    // hsync stops: one timeout pulse when hp reaches 2*H_TOTAL, none after.
    run_to(0, 2);
    hs_en = 1'b0;
    run_to(17, 3);
    check_ab("tmo_pre_line_pulses", lc_a, lc_b, lc0);
    step();
    check_ab("tmo_line_pulses", lc_a, lc_b, lc0 + 1);
    check_ab("tmo_locked", locked_a, locked_b, 0);
    check_ab("tmo_err_count", err_count_a, err_count_b, 1);
    run_to(0, 6);
    check_ab("tmo_no_repeat", lc_a, lc_b, lc0 + 1);
    check_ab("tmo_frame_pulses", fc_a, fc_b, fc0);
    check_ab("tmo_err_count_end", err_count_a, err_count_b, 1);
    hs_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
